regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the single write port of the 16x8 register file between two writeback requesters: req0 (ALU result) and req1 (load data). Arbitration is round-robin with a valid/ready handshake per requester. The block also sequences a software-triggered clear that walks every register to CLR_VALUE. It sits between the execute/memory stages and the register file write_enable/write_addr/write_data inputs.

Parameters:
ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W
DATA_W, 8, register data width
CLR_VALUE, 0, value written to each register during a clear sweep

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
req0_valid  in  1  ALU writeback request
req0_addr  in  ADDR_W  ALU destination register
req0_data  in  DATA_W  ALU result
req0_ready  out  1  req0 accepted this cycle (combinational)
req1_valid  in  1  load writeback request
req1_addr  in  ADDR_W  load destination register
req1_data  in  DATA_W  load data
req1_ready  out  1  req1 accepted this cycle (combinational)
clr_start  in  1  one-cycle pulse: start clear sweep
busy  out  1  clear sweep in progress (registered)
rf_we  out  1  to register file write_enable (registered)
rf_waddr  out  ADDR_W  to register file write_addr (registered)
rf_wdata  out  DATA_W  to register file write_data (registered)

Behaviour:
- Reset (rst_n=0, async): rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, state=ARB, prio=0 (req0 favoured), sweep counter=0. Reset asserted mid-sweep aborts it; no further writes.
- States: ARB, CLEAR.
- ARB grant: only req0 valid -> grant 0; only req1 valid -> grant 1; both valid -> grant the requester selected by prio. reqN_ready=1 only for the granted requester; both 0 in CLEAR or when clr_start=1.
- Transfer = valid & ready. After a transfer on requester i, prio <= other requester; prio unchanged when no transfer occurs.
- Latency: transfer in cycle N -> rf_we=1, rf_waddr/rf_wdata = granted addr/data in cycle N+1. Cycles with no transfer -> rf_we=0 next cycle; rf_waddr/rf_wdata hold their last values.
- Requesters hold valid/addr/data stable until ready; the losing requester is served in the next cycle. Back-to-back transfers sustain one write per cycle.
- Both requesters targeting the same address in the same cycle: only the granted one is written that cycle; the other is written in a later cycle (last writer wins in register file).
- clr_start=1 in ARB in cycle N: takes priority over requests (no grant in N). State -> CLEAR. rf_we=1, rf_waddr=k, rf_wdata=CLR_VALUE in cycle N+1+k, k=0..NUM_REGS-1. busy=1 in cycles N+1..N+NUM_REGS. ARB resumes in cycle N+NUM_REGS+1. Counter does not wrap back into a second sweep.
- clr_start during CLEAR: ignored. A write from a transfer in cycle N-1 still appears in cycle N, before the sweep.
- prio is unchanged by a sweep.

Test Plan:
- Reset then idle: rst_n low mid-cycle -> rf_we=0, busy=0 immediately; no valids -> rf_we stays 0.
- Single request: req0 valid addr=3 data=0xA5 in cycle 1 -> req0_ready=1 in cycle 1; rf_we=1, rf_waddr=3, rf_wdata=0xA5 in cycle 2 only.
- Contention: both valid continuously, req0 addr=1 data=0x11, req1 addr=2 data=0x22, from reset -> grants 0,1,0,1 in alternate cycles; rf writes addr 1,2,1,2 one cycle later, rf_we=1 every cycle.
- Same address: req0 addr=5 data=0x10, req1 addr=5 data=0x20, same cycle, prio=0 -> writes 0x10 then 0x20 on consecutive cycles; final register 5 = 0x20.
- Clear sweep: clr_start pulse in cycle 10 with req1 valid -> req1_ready=0 in cycles 10..26; rf writes addr 0..15 data 0x00 in cycles 11..26; busy=1 in cycles 11..26; req1 accepted in cycle 27 and written in cycle 28.
- Reset mid-sweep: rst_n low in cycle 15 of the sweep (after addr 3 written) -> rf_we=0 and busy=0 at once; state ARB after rst_n high; addr 4..15 never written.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port between two writeback
// requesters (req0 = ALU result, req1 = load data). Grants are round-robin
// with a valid/ready handshake per requester. A clr_start pulse runs a sweep
// that writes CLR_VALUE to every register, one register per cycle.
// All register-file outputs are registered, so a transfer accepted in
// cycle N is written in cycle N+1.

module regfile_wb_arbiter #(
  parameter int unsigned          ADDR_W    = 4,
  parameter int unsigned          DATA_W    = 8,
  parameter logic [DATA_W-1:0]    CLR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              clr_start,
  output logic              busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  // Arbitrating between requesters, or walking the clear sweep.
  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Address of the final register in the sweep (all ones).
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [0:0]        state;
  logic              prio;       // 0: req0 wins a tie, 1: req1 wins a tie
  logic [ADDR_W-1:0] sweep_cnt;  // address currently presented by the sweep

  logic              arb_open;
  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic [ADDR_W-1:0] xfer_addr;
  logic [DATA_W-1:0] xfer_data;

  // Grant selection: a pending clear request or an active sweep blocks both
  // requesters; otherwise a lone requester wins and a tie goes to prio.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and turn it into a latch.
    arb_open  = (state == ST_ARB) && !clr_start;
    grant0    = 1'b0;
    grant1    = 1'b0;
    xfer_addr = req0_addr;
    xfer_data = req0_data;
    if (arb_open) begin
      if (req0_valid && (!req1_valid || !prio)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1    = 1'b1;
        xfer_addr = req1_addr;
        xfer_data = req1_data;
      end
    end
    xfer = grant0 || grant1;
  end

  // Ready is only ever raised for the granted (and therefore valid) requester.
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // State, priority, sweep counter and the registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    if (!rst_n) begin
      state     <= ST_ARB;
      prio      <= 1'b0;
      sweep_cnt <= '0;
      busy      <= 1'b0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
    end else begin
      case (state)
        ST_ARB: begin
          if (clr_start) begin
            // First sweep write (register 0) appears in the next cycle.
            state     <= ST_CLEAR;
            sweep_cnt <= '0;
            busy      <= 1'b1;
            rf_we     <= 1'b1;
            rf_waddr  <= '0;
            rf_wdata  <= CLR_VALUE;
          end else if (xfer) begin
            rf_we    <= 1'b1;
            rf_waddr <= xfer_addr;
            rf_wdata <= xfer_data;
            prio     <= grant0;  // hand the tie-break to the other side
          end else begin
            // Idle: drop the strobe, keep address/data as they were.
            rf_we <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (sweep_cnt == LAST_ADDR) begin
            // Last register is on the port this cycle; end the sweep
            // rather than wrapping into a second pass.
            state <= ST_ARB;
            busy  <= 1'b0;
            rf_we <= 1'b0;
          end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
            rf_we     <= 1'b1;
            rf_waddr  <= sweep_cnt + 1'b1;
            rf_wdata  <= CLR_VALUE;
          end
        end
        default: begin
          state <= ST_ARB;
          busy  <= 1'b0;
          rf_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter. Stimulus pushes each expected register
// file write (address, data, cycle) into a queue; a monitor pops and compares
// whenever the DUT strobes rf_we. Handshake and busy values are checked
// directly by the stimulus process.

module tb_regfile_wb_arbiter;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int NREGS  = 16;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0_valid, req1_valid, clr_start;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              req0_ready, req1_ready, busy, rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  wr_t               exp_q[$];
  logic [DATA_W-1:0] rf_model [NREGS];
  int                cyc_cnt = 0;
  int                n_checks = 0;
  int                n_fail = 0;
  int                c0;

  regfile_wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLR_VALUE('0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .clr_start  (clr_start),
    .busy       (busy),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc_cnt, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write at cycle %0d: addr 0x%0h data 0x%0h, expected none",
                 cyc_cnt, rf_waddr, rf_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(rf_waddr), 32'(e.addr));
        check("wr_data", 32'(rf_wdata), 32'(e.data));
        check("wr_cycle", 32'(cyc_cnt), 32'(e.cyc));
        rf_model[rf_waddr] = rf_wdata;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                       input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                       input logic clr);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    clr_start  = clr;
  endtask

  task automatic idle;
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int c);
    wr_t e;
    e.addr = a; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Sample handshake/busy mid-cycle, away from the active edge.
  task automatic chk_hs(input string name, input logic e0, input logic e1, input logic eb);
    @(negedge clk);
    check({name, "_ready0"}, 32'(req0_ready), 32'(e0));
    check({name, "_ready1"}, 32'(req1_ready), 32'(e1));
    check({name, "_busy"},   32'(busy),       32'(eb));
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) rf_model[i] = 8'hFF;
    idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_we",    32'(rf_we),    32'd0);
    check("rst_busy",  32'(busy),     32'd0);
    check("rst_waddr", 32'(rf_waddr), 32'd0);
    check("rst_wdata", 32'(rf_wdata), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle: no valids, no writes, no readiness.
    repeat (3) begin
      next_cycle();
      chk_hs("idle", 1'b0, 1'b0, 1'b0);
    end

    // Single req0 request.
    next_cycle();
    drive(1'b1, 4'd3, 8'hA5, 1'b0, '0, '0, 1'b0);
    expect_wr(4'd3, 8'hA5, cyc_cnt + 1);
    chk_hs("single", 1'b1, 1'b0, 1'b0);
    next_cycle();
    idle();
    chk_hs("single_after", 1'b0, 1'b0, 1'b0);
    next_cycle();
    chk_hs("single_idle", 1'b0, 1'b0, 1'b0);

    // Contention from reset: alternating grants, one write per cycle.
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'd1, 8'h11, 1'b1, 4'd2, 8'h22, 1'b0);
      if (i % 2 == 0) expect_wr(4'd1, 8'h11, cyc_cnt + 1);
      else            expect_wr(4'd2, 8'h22, cyc_cnt + 1);
      chk_hs("contend", (i % 2 == 0), (i % 2 == 1), 1'b0);
      next_cycle();
    end
    idle();
    chk_hs("contend_end", 1'b0, 1'b0, 1'b0);
    next_cycle();

    // Same address, prio back at req0: 0x10 then 0x20 on consecutive cycles.
    drive(1'b1, 4'd5, 8'h10, 1'b1, 4'd5, 8'h20, 1'b0);
    expect_wr(4'd5, 8'h10, cyc_cnt + 1);
    chk_hs("same0", 1'b1, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, '0, '0, 1'b1, 4'd5, 8'h20, 1'b0);
    expect_wr(4'd5, 8'h20, cyc_cnt + 1);
    chk_hs("same1", 1'b0, 1'b1, 1'b0);
    next_cycle();
    idle();
    chk_hs("same_end", 1'b0, 1'b0, 1'b0);
    next_cycle();
    chk_hs("same_idle", 1'b0, 1'b0, 1'b0);
    check("same_final_reg5", 32'(rf_model[5]), 32'h20);

    // Clear sweep with req1 waiting; a second clr_start mid-sweep is ignored.
    next_cycle();
    c0 = cyc_cnt;
    for (int k = 0; k < NREGS; k++) expect_wr(ADDR_W'(k), 8'h00, c0 + 1 + k);
    for (int i = 0; i <= NREGS + 1; i++) begin
      drive(1'b0, '0, '0, 1'b1, 4'd7, 8'h77, (i == 0 || i == 5));
      if (i == NREGS + 1) expect_wr(4'd7, 8'h77, cyc_cnt + 1);
      chk_hs("sweep", 1'b0, (i == NREGS + 1), (i >= 1 && i <= NREGS));
      next_cycle();
    end
    idle();
    chk_hs("sweep_done", 1'b0, 1'b0, 1'b0);
    next_cycle();
    chk_hs("sweep_idle", 1'b0, 1'b0, 1'b0);
    check("sweep_reg0", 32'(rf_model[0]), 32'h00);
    check("sweep_reg15", 32'(rf_model[15]), 32'h00);
    check("sweep_reg7", 32'(rf_model[7]), 32'h77);

    // Reset in the middle of a sweep, right after register 3 was written.
    for (int i = 0; i < NREGS; i++) rf_model[i] = 8'hFF;
    next_cycle();
    c0 = cyc_cnt;
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    for (int k = 0; k < 4; k++) expect_wr(ADDR_W'(k), 8'h00, c0 + 1 + k);
    chk_hs("abort_start", 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      idle();
      chk_hs("abort_sweep", 1'b0, 1'b0, 1'b1);
    end
    #1 rst_n = 1'b0;
    #1;
    check("abort_we",    32'(rf_we),    32'd0);
    check("abort_busy",  32'(busy),     32'd0);
    check("abort_waddr", 32'(rf_waddr), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    next_cycle();
    drive(1'b1, 4'd9, 8'h99, 1'b0, '0, '0, 1'b0);
    expect_wr(4'd9, 8'h99, cyc_cnt + 1);
    chk_hs("abort_arb", 1'b1, 1'b0, 1'b0);
    next_cycle();
    idle();
    repeat (4) begin
      chk_hs("abort_idle", 1'b0, 1'b0, 1'b0);
      next_cycle();
    end
    check("abort_reg3", 32'(rf_model[3]), 32'h00);
    check("abort_reg4_untouched", 32'(rf_model[4]), 32'hFF);
    check("abort_reg15_untouched", 32'(rf_model[15]), 32'hFF);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
